// File: rtl/mem_pkg.sv
// mem_pkg: shared definitions for the memory arbiter slice.
//   - Length codes carried on ls_len / mem_len: bits [1:0] select
//     byte/half/word, bit LEN_SIGNED marks a sign-extending load.
//   - arb_state_e: arbiter state encoding, also exported on dbg_state.
package mem_pkg;

    localparam logic [2:0] LEN_B      = 3'b000;
    localparam logic [2:0] LEN_H      = 3'b001;
    localparam logic [2:0] LEN_W      = 3'b010;
    localparam int         LEN_SIGNED = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } arb_state_e;

endpackage

// File: rtl/arb_pick.sv
// arb_pick: combinational winner selection between the instruction-fetch
// and load/store requesters.
//   i_if_elig     fetch request is eligible this cycle
//   i_ls_elig     load/store request is eligible this cycle
//   i_ls_first    on contention, grant the load/store side
//   o_grant_valid at least one eligible request
//   o_grant_ls    1 = load/store wins, 0 = fetch wins (valid with o_grant_valid)
module arb_pick
    import mem_pkg::*;
(
    input  logic i_if_elig,
    input  logic i_ls_elig,
    input  logic i_ls_first,
    output logic o_grant_valid,
    output logic o_grant_ls
);

    assign o_grant_valid = i_if_elig | i_ls_elig;
    // LSU wins when alone, or on contention when the pointer favours it.
    assign o_grant_ls    = i_ls_elig & (~i_if_elig | i_ls_first);

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester (fetch, load/store) arbiter in front of a
// single memory controller. One task in flight at a time:
// IDLE -> ISSUE (mem_valid held until mem_ready) -> RESP (one-cycle ready
// pulse to the granted requester) -> IDLE.
//
// Handshake: a requester holds req and payload stable until its ready pulse
// and drops req the cycle after. mem_* hold stable while mem_valid is high;
// the task completes on the edge where mem_ready is high. rdy_in low freezes
// every register.
//
// Ports:
//   clk_in, rst_n_in         clock, async active-low reset
//   rdy_in                   global ready (low = hold)
//   if_req/if_addr           fetch request; if_ready/if_data response
//   ls_req/ls_write/ls_addr/ls_data/ls_len  load/store request;
//   ls_ready/ls_result       load/store response
//   flush                    cancels pending or outstanding fetches
//   mem_valid/mem_write/mem_addr/mem_data/mem_len  task to memory controller
//   mem_ready/mem_result     completion pulse and result from controller
//   dbg_state                current arbiter state (arb_state_e encoding)
//
// Build option: ARB_ROUND_ROBIN_EN -- when defined, contention alternates
// using a last-grant pointer; otherwise the LSU always wins contention.
module mem_arbiter
    import mem_pkg::*;
#(
    parameter logic [2:0] IF_LEN = 3'b010
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        rdy_in,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ready,
    output logic [31:0] if_data,
    input  logic        ls_req,
    input  logic        ls_write,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_data,
    input  logic [2:0]  ls_len,
    output logic        ls_ready,
    output logic [31:0] ls_result,
    input  logic        flush,
    output logic        mem_valid,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_data,
    output logic [2:0]  mem_len,
    input  logic        mem_ready,
    input  logic [31:0] mem_result,
    output logic [1:0]  dbg_state
);

    arb_state_e r_state;
    arb_state_e w_state_nxt;
    logic       r_grant_ls;
    logic       r_drop;
    logic       w_if_elig;
    logic       w_ls_elig;
    logic       w_ls_first;
    logic       w_grant_valid;
    logic       w_grant_ls;
    logic       w_fetch_dropped;

    assign w_if_elig = if_req & ~flush;
    assign w_ls_elig = ls_req;

`ifdef ARB_ROUND_ROBIN_EN
    logic r_ls_first;

    // Pointer favours the side not granted last; moves on every grant.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_ls_first <= 1'b1;
        end else if (rdy_in && (r_state == ST_IDLE) && w_grant_valid) begin
            r_ls_first <= ~w_grant_ls;
        end
    end

    assign w_ls_first = r_ls_first;
`else
    assign w_ls_first = 1'b1;
`endif

    arb_pick u_pick (
        .i_if_elig    (w_if_elig),
        .i_ls_elig    (w_ls_elig),
        .i_ls_first   (w_ls_first),
        .o_grant_valid(w_grant_valid),
        .o_grant_ls   (w_grant_ls)
    );

    // A flush on the completion edge itself also cancels the fetch response.
    assign w_fetch_dropped = r_drop | flush;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_grant_valid) w_state_nxt = ST_ISSUE;
            ST_ISSUE: if (mem_ready)     w_state_nxt = ST_RESP;
            ST_RESP:                     w_state_nxt = ST_IDLE;
            default:                     w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state <= ST_IDLE;
        end else if (rdy_in) begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_grant_ls <= 1'b0;
            r_drop     <= 1'b0;
            mem_valid  <= 1'b0;
            mem_write  <= 1'b0;
            mem_addr   <= '0;
            mem_data   <= '0;
            mem_len    <= '0;
            if_ready   <= 1'b0;
            if_data    <= '0;
            ls_ready   <= 1'b0;
            ls_result  <= '0;
        end else if (rdy_in) begin
            if_ready <= 1'b0;
            ls_ready <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_valid) begin
                        mem_valid  <= 1'b1;
                        r_grant_ls <= w_grant_ls;
                        if (w_grant_ls) begin
                            mem_write <= ls_write;
                            mem_addr  <= ls_addr;
                            mem_data  <= ls_data;
                            mem_len   <= ls_len;
                        end else begin
                            mem_write <= 1'b0;
                            mem_addr  <= if_addr;
                            mem_data  <= '0;
                            mem_len   <= IF_LEN;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (!r_grant_ls && flush) begin
                        r_drop <= 1'b1;
                    end
                    if (mem_ready) begin
                        mem_valid <= 1'b0;
                        if (r_grant_ls) begin
                            ls_result <= mem_result;
                            ls_ready  <= 1'b1;
                        end else if (!w_fetch_dropped) begin
                            // Dropped fetches leave if_data untouched.
                            if_data  <= mem_result;
                            if_ready <= 1'b1;
                        end
                    end
                end
                ST_RESP: begin
                    r_drop <= 1'b0;
                end
                default: begin
                    r_drop <= 1'b0;
                end
            endcase
        end
    end

    assign dbg_state = r_state;

endmodule
